// File: rtl/iahb_arb_pkg.sv
// Shared AHB-Lite encodings and owner states for the two-master program-RAM arbiter.
package iahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Which master currently holds the slave data phase.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // NONSEQ or SEQ while the master's previous phase is completing; IDLE/BUSY never forwarded.
  function automatic logic is_live(input logic hready, input logic [1:0] htrans);
    return hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/iahb_arb_req_buf.sv
// One-entry address-phase buffer: holds a master's packed address phase while it waits for a grant.
module iahb_arb_req_buf #(
  parameter int PW = 43
) (
  input  logic          sys_clk,
  input  logic          sys_resetn,
  input  logic          load,
  input  logic          clear,
  input  logic [PW-1:0] load_phase,
  output logic          valid,
  output logic [PW-1:0] phase
);

  always_ff @(posedge sys_clk) begin
    if (!sys_resetn)  valid <= 1'b0;
    else if (load)    valid <= 1'b1;
    else if (clear)   valid <= 1'b0;
  end

  // NOTE: the payload has no reset; it is only observed while valid is set,
  // so resetting it would add reset fan-out without changing behaviour.
  always_ff @(posedge sys_clk) begin
    if (load) phase <= load_phase;
  end

endmodule

// File: rtl/iahb_mem_arbiter.sv
// Round-robin two-master AHB-Lite arbiter in front of the program RAM, with a
// one-entry address buffer per master so a losing master stalls without losing its transfer.
module iahb_mem_arbiter
  import iahb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          sys_clk,
  input  logic          sys_resetn,

  input  logic [AW-1:0] m0_haddr,
  input  logic [1:0]    m0_htrans,
  input  logic [2:0]    m0_hsize,
  input  logic [2:0]    m0_hburst,
  input  logic [3:0]    m0_hprot,
  input  logic          m0_hwrite,
  input  logic [DW-1:0] m0_hwdata,
  output logic [DW-1:0] m0_hrdata,
  output logic          m0_hready,
  output logic          m0_hresp,

  input  logic [AW-1:0] m1_haddr,
  input  logic [1:0]    m1_htrans,
  input  logic [2:0]    m1_hsize,
  input  logic [2:0]    m1_hburst,
  input  logic [3:0]    m1_hprot,
  input  logic          m1_hwrite,
  input  logic [DW-1:0] m1_hwdata,
  output logic [DW-1:0] m1_hrdata,
  output logic          m1_hready,
  output logic          m1_hresp,

  output logic [AW-1:0] s_haddr,
  output logic [1:0]    s_htrans,
  output logic [2:0]    s_hsize,
  output logic [2:0]    s_hburst,
  output logic [3:0]    s_hprot,
  output logic          s_hwrite,
  output logic [DW-1:0] s_hwdata,
  input  logic [DW-1:0] s_hrdata,
  input  logic          s_hready,
  input  logic          s_hresp
);

  localparam int PW = AW + 3 + 3 + 4 + 1;

  owner_e        owner, owner_nxt;
  logic          last_m1;
  logic          pend0, pend1;
  logic          live0, live1, req0, req1, grant0, grant1;
  logic [PW-1:0] bus0, bus1, buf0, buf1, sel;

  assign bus0 = {m0_haddr, m0_hsize, m0_hburst, m0_hprot, m0_hwrite};
  assign bus1 = {m1_haddr, m1_hsize, m1_hburst, m1_hprot, m1_hwrite};

  // Master-side handshake depends only on registered state and the slave, never on the grant.
  always_comb begin
    m0_hready = 1'b1;
    m0_hresp  = HRESP_OKAY;
    m1_hready = 1'b1;
    m1_hresp  = HRESP_OKAY;
    if (sys_resetn) begin
      if (owner == OWN_M0) begin
        m0_hready = s_hready;
        m0_hresp  = s_hresp;
      end else if (pend0) begin
        m0_hready = 1'b0;
      end
      if (owner == OWN_M1) begin
        m1_hready = s_hready;
        m1_hresp  = s_hresp;
      end else if (pend1) begin
        m1_hready = 1'b0;
      end
    end
  end

  assign live0 = is_live(m0_hready, m0_htrans);
  assign live1 = is_live(m1_hready, m1_htrans);
  assign req0  = pend0 | live0;
  assign req1  = pend1 | live1;

  // On a tie the master that was not granted last wins.
  assign grant0 = sys_resetn & s_hready & req0 & (~req1 | last_m1);
  assign grant1 = sys_resetn & s_hready & req1 & (~req0 | ~last_m1);

  always_comb begin
    owner_nxt = owner;
    if (s_hready) begin
      if (grant0)      owner_nxt = OWN_M0;
      else if (grant1) owner_nxt = OWN_M1;
      else             owner_nxt = OWN_NONE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) begin
      owner   <= OWN_NONE;
      last_m1 <= 1'b1;
    end else begin
      owner <= owner_nxt;
      if (grant0)      last_m1 <= 1'b0;
      else if (grant1) last_m1 <= 1'b1;
    end
  end

  iahb_arb_req_buf #(.PW(PW)) u_buf0 (
    .sys_clk    (sys_clk),
    .sys_resetn (sys_resetn),
    .load       (live0 & ~grant0),
    .clear      (grant0),
    .load_phase (bus0),
    .valid      (pend0),
    .phase      (buf0)
  );

  iahb_arb_req_buf #(.PW(PW)) u_buf1 (
    .sys_clk    (sys_clk),
    .sys_resetn (sys_resetn),
    .load       (live1 & ~grant1),
    .clear      (grant1),
    .load_phase (bus1),
    .valid      (pend1),
    .phase      (buf1)
  );

  always_comb begin
    sel = '0;
    if (grant0)      sel = pend0 ? buf0 : bus0;
    else if (grant1) sel = pend1 ? buf1 : bus1;
  end

  assign {s_haddr, s_hsize, s_hburst, s_hprot, s_hwrite} = sel;
  assign s_htrans  = (grant0 | grant1) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s_hwdata  = (owner == OWN_M1) ? m1_hwdata : m0_hwdata;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

endmodule

// File: tb/tb_iahb_mem_arbiter.sv
// Self-checking bench: random and directed AHB traffic against a transaction-level arbiter model.
module tb_iahb_mem_arbiter;
  import iahb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          sys_clk = 1'b0;
  logic          sys_resetn = 1'b0;
  logic [AW-1:0] m0_haddr, m1_haddr, s_haddr;
  logic [1:0]    m0_htrans, m1_htrans, s_htrans;
  logic [2:0]    m0_hsize, m1_hsize, s_hsize, m0_hburst, m1_hburst, s_hburst;
  logic [3:0]    m0_hprot, m1_hprot, s_hprot;
  logic          m0_hwrite, m1_hwrite, s_hwrite;
  logic [DW-1:0] m0_hwdata, m1_hwdata, s_hwdata, m0_hrdata, m1_hrdata, s_hrdata;
  logic          m0_hready, m1_hready, m0_hresp, m1_hresp, s_hready, s_hresp;

  iahb_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hprot(m0_hprot), .m0_hwrite(m0_hwrite), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
    .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hprot(m1_hprot), .m1_hwrite(m1_hwrite), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
    .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hprot(s_hprot), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
    .s_hready(s_hready), .s_hresp(s_hresp)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic rdy;
    logic resp;
  } srsp_t;

  // Bench masters: address phase on the bus and data held for the master's own data phase.
  xfer_t       a_ph [2];
  logic [31:0] d_wdata [2];
  xfer_t       dq0 [$];
  xfer_t       dq1 [$];
  int          req_pct [2];

  srsp_t sl_q [$];
  int    wait_pct;
  int    rst_cycles;

  // Reference model: transfers accepted from a master but not yet issued to the slave.
  xfer_t pq0 [$];
  xfer_t pq1 [$];
  int    last_m;
  int    sdp_m;
  xfer_t sdp_x;
  int    acc [2];
  int    issued [2];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic xfer_t idle_x();
    xfer_t x;
    x = '{valid: 1'b0, addr: 32'h0, write: 1'b0, size: 3'd0, burst: 3'd0, prot: 4'd0, wdata: 32'h0};
    return x;
  endfunction

  function automatic xfer_t mk(input logic [31:0] addr, input logic write, input logic [31:0] wdata);
    xfer_t x;
    x = '{valid: 1'b1, addr: addr, write: write, size: 3'd2, burst: 3'd0, prot: 4'b0011, wdata: wdata};
    return x;
  endfunction

  function automatic xfer_t rnd_x();
    xfer_t x;
    x = mk($urandom & 32'hFFFF_FFFC, 1'($urandom_range(1)), $urandom);
    x.burst = 3'($urandom_range(7));
    x.prot  = 4'($urandom_range(15));
    x.size  = 3'($urandom_range(2));
    return x;
  endfunction

  function automatic xfer_t next_x(input int m);
    xfer_t x;
    x = idle_x();
    if (m == 0 && dq0.size() > 0)      x = dq0.pop_front();
    else if (m == 1 && dq1.size() > 0) x = dq1.pop_front();
    else if ($urandom_range(99) < req_pct[m]) x = rnd_x();
    return x;
  endfunction

  function automatic int psize(input int m);
    return (m == 0) ? pq0.size() : pq1.size();
  endfunction

  task automatic drive_master(input int m);
    logic [1:0] tr;
    tr = a_ph[m].valid ? HTRANS_NONSEQ : ($urandom_range(1) ? HTRANS_BUSY : HTRANS_IDLE);
    if (m == 0) begin
      m0_htrans = tr; m0_haddr = a_ph[0].addr; m0_hwrite = a_ph[0].write; m0_hsize = a_ph[0].size;
      m0_hburst = a_ph[0].burst; m0_hprot = a_ph[0].prot; m0_hwdata = d_wdata[0];
    end else begin
      m1_htrans = tr; m1_haddr = a_ph[1].addr; m1_hwrite = a_ph[1].write; m1_hsize = a_ph[1].size;
      m1_hburst = a_ph[1].burst; m1_hprot = a_ph[1].prot; m1_hwdata = d_wdata[1];
    end
  endtask

  task automatic step();
    xfer_t head [2];
    logic  erdy [2];
    logic  eresp [2];
    logic  live [2];
    logic  req [2];
    srsp_t r;
    int    win;

    @(posedge sys_clk);
    #1;
    sys_resetn = (rst_cycles == 0);
    if (rst_cycles > 0) rst_cycles--;
    drive_master(0);
    drive_master(1);
    if (sl_q.size() > 0) r = sl_q.pop_front();
    else r = '{rdy: ($urandom_range(99) >= wait_pct), resp: 1'b0};
    s_hready = r.rdy;
    s_hresp  = r.resp;
    s_hrdata = $urandom;

    @(negedge sys_clk);
    for (int m = 0; m < 2; m++) begin
      erdy[m] = 1'b1; eresp[m] = 1'b0;
      if (sys_resetn) begin
        if (sdp_m == m) begin erdy[m] = s_hready; eresp[m] = s_hresp; end
        else if (psize(m) > 0) erdy[m] = 1'b0;
      end
      live[m] = erdy[m] && a_ph[m].valid;
      req[m]  = (psize(m) > 0) || live[m];
      if (m == 0) head[m] = (pq0.size() > 0) ? pq0[0] : a_ph[0];
      else        head[m] = (pq1.size() > 0) ? pq1[0] : a_ph[1];
    end
    check("m0_hready", 64'(m0_hready), 64'(erdy[0]));
    check("m1_hready", 64'(m1_hready), 64'(erdy[1]));
    check("m0_hresp",  64'(m0_hresp),  64'(eresp[0]));
    check("m1_hresp",  64'(m1_hresp),  64'(eresp[1]));
    check("m0_hrdata", 64'(m0_hrdata), 64'(s_hrdata));
    check("m1_hrdata", 64'(m1_hrdata), 64'(s_hrdata));

    win = -1;
    if (sys_resetn && s_hready) begin
      if (req[0] && req[1]) win = 1 - last_m;
      else if (req[0])      win = 0;
      else if (req[1])      win = 1;
    end
    check("s_htrans", 64'(s_htrans), 64'((win >= 0) ? HTRANS_NONSEQ : HTRANS_IDLE));
    if (win >= 0) begin
      check($sformatf("s_haddr_m%0d", win),  64'(s_haddr),  64'(head[win].addr));
      check($sformatf("s_hwrite_m%0d", win), 64'(s_hwrite), 64'(head[win].write));
      check($sformatf("s_hsize_m%0d", win),  64'(s_hsize),  64'(head[win].size));
      check($sformatf("s_hburst_m%0d", win), 64'(s_hburst), 64'(head[win].burst));
      check($sformatf("s_hprot_m%0d", win),  64'(s_hprot),  64'(head[win].prot));
    end
    if (sys_resetn && sdp_m >= 0 && sdp_x.write)
      check($sformatf("s_hwdata_m%0d", sdp_m), 64'(s_hwdata), 64'(sdp_x.wdata));

    if (!sys_resetn) begin
      pq0.delete(); pq1.delete();
      sdp_m = -1; last_m = 1;
      for (int m = 0; m < 2; m++) begin
        a_ph[m] = idle_x(); d_wdata[m] = $urandom; acc[m] = issued[m];
      end
    end else begin
      if (s_hready) begin
        sdp_m = win;
        if (win >= 0) begin
          if (win == 0 && pq0.size() > 0) void'(pq0.pop_front());
          if (win == 1 && pq1.size() > 0) void'(pq1.pop_front());
          issued[win]++;
          last_m = win;
          sdp_x  = head[win];
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (live[m]) begin
          acc[m]++;
          if (m != win) begin
            if (m == 0) pq0.push_back(a_ph[0]);
            else        pq1.push_back(a_ph[1]);
          end
        end
        if (erdy[m]) begin
          d_wdata[m] = a_ph[m].valid ? a_ph[m].wdata : $urandom;
          a_ph[m]    = next_x(m);
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain_and_count(input string tag);
    req_pct[0] = 0; req_pct[1] = 0; wait_pct = 0;
    run(8);
    check({tag, "_m0_count"}, 64'(issued[0]), 64'(acc[0]));
    check({tag, "_m1_count"}, 64'(issued[1]), 64'(acc[1]));
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      a_ph[m] = idle_x(); d_wdata[m] = 32'h0; req_pct[m] = 0; acc[m] = 0; issued[m] = 0;
    end
    sdp_m = -1; last_m = 1; wait_pct = 0; rst_cycles = 2;
    drive_master(0); drive_master(1);
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h0;

    // Reset and an uncontended M0 read.
    run(2);
    dq0.push_back(mk(32'h0000_0100, 1'b0, 32'h0));
    run(4);

    // Both masters in the first cycle after reset; M0 wins the tie, M1 is buffered.
    rst_cycles = 1;
    run(1);
    a_ph[0] = mk(32'h0000_0000, 1'b0, 32'h0);
    a_ph[1] = mk(32'h2000_0010, 1'b1, 32'hDEAD_BEEF);
    run(4);

    // Back-to-back contention: grants alternate, nothing lost or duplicated.
    req_pct[0] = 100; req_pct[1] = 100;
    run(40);
    drain_and_count("rr");

    // Slave wait states while M1 presents a read.
    dq1.push_back(mk(32'h0000_0040, 1'b0, 32'h0));
    run(1);
    sl_q.push_back('{rdy: 1'b0, resp: 1'b0});
    sl_q.push_back('{rdy: 1'b0, resp: 1'b0});
    sl_q.push_back('{rdy: 1'b1, resp: 1'b0});
    run(4);

    // Two-cycle ERROR response on an M0 transfer, then an M1 write.
    dq0.push_back(mk(32'h0000_0080, 1'b0, 32'h0));
    run(1);
    sl_q.push_back('{rdy: 1'b1, resp: 1'b0});
    sl_q.push_back('{rdy: 1'b0, resp: 1'b1});
    sl_q.push_back('{rdy: 1'b1, resp: 1'b1});
    run(3);
    dq1.push_back(mk(32'h0000_0300, 1'b1, 32'h1234_5678));
    run(4);

    // Reset while one master is buffered; the buffered address must never issue.
    dq0.push_back(mk(32'h0000_0500, 1'b0, 32'h0));
    dq1.push_back(mk(32'h0000_0600, 1'b0, 32'h0));
    run(2);
    rst_cycles = 1;
    run(4);

    // Randomized traffic with random slave wait states and an occasional reset.
    req_pct[0] = 60; req_pct[1] = 60; wait_pct = 30;
    run(300);
    rst_cycles = 1;
    run(200);
    drain_and_count("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iahb_mem_arbiter.md
Name: iahb_mem_arbiter

Overview:
- Two-master to one-slave AHB-Lite arbiter that shares the instruction/program RAM (cpu_mem) between two masters:
  - M0: the E902 instruction bus (iahbl).
  - M1: a secondary master, such as the program loader or the system-bus window into program RAM.
- Sits between openE902 and cpu_mem in soc.
- Arbitration is round-robin, with one-entry address-phase buffering per master, so a master whose address is not granted is stalled without losing the transfer.

Parameters:
- AW, 32, address width.
- DW, 32, data width.

Ports:
- sys_clk  in  1  system clock.
- sys_resetn  in  1  reset, synchronous, active-low.
- m0_haddr / m1_haddr  in  AW  master address.
- m0_htrans / m1_htrans  in  2  master transfer type.
- m0_hsize / m1_hsize  in  3  master size.
- m0_hburst / m1_hburst  in  3  master burst (forwarded only).
- m0_hprot / m1_hprot  in  4  master protection (forwarded only).
- m0_hwrite / m1_hwrite  in  1  master write.
- m0_hwdata / m1_hwdata  in  DW  master write data.
- m0_hrdata / m1_hrdata  out  DW  read data returned to master.
- m0_hready / m1_hready  out  1  ready returned to master.
- m0_hresp / m1_hresp  out  1  response to master (0 OKAY, 1 ERROR).
- s_haddr / s_hsize / s_hburst / s_hprot / s_hwrite  out  AW/3/3/4/1  slave address-phase signals.
- s_htrans  out  2  slave transfer type.
- s_hwdata  out  DW  slave write data.
- s_hrdata  in  DW  slave read data.
- s_hready  in  1  slave ready; must not depend combinationally on s_htrans.
- s_hresp  in  1  slave response.

Behaviour:
- Clock and reset: one clock, sys_clk. sys_resetn is synchronous, active-low.
- State:
  - owner[1:0]: NONE / M0 / M1; records which master holds the slave data phase.
  - last: the master granted most recently.
  - pend0, pend1: valid bits for the per-master buffers.
  - buf0, buf1: each holds haddr, hsize, hburst, hprot, hwrite.
- Reset values: owner=NONE, last=M1 (so M0 wins the first tie), pend0=pend1=0. Outputs under reset: mX_hready=1, mX_hresp=0, s_htrans=IDLE.
- Live request: liveX = mX_hready & mX_htrans[1] (NONSEQ or SEQ).
  - IDLE and BUSY are never forwarded.
  - BUSY is treated as IDLE; E902 issues SINGLE bursts only.
- Request: reqX = pendX | liveX. pendX and liveX are mutually exclusive by construction.
- Arbitration runs only when s_hready=1.
  - Exactly one requester: it is granted.
  - Both requesting: the master other than last is granted, and last is updated to it.
- Granted master, same cycle:
  - Its address source (buffer if pendX, otherwise live bus) drives s_*, with s_htrans=NONSEQ.
  - At the clock edge: owner<=X and pendX<=0.
- Ungranted live request: captured into bufX at the edge, pendX<=1. From the master's view its address phase has completed.
- s_hready=0:
  - No grant; s_htrans=IDLE (an IDLE to NONSEQ change during a wait is legal).
  - Any live request is captured into its buffer.
- No grant while s_hready=1: s_htrans=IDLE and owner<=NONE at the edge.
- Master ready and response:
  - owner==X: mX_hready=s_hready, mX_hresp=s_hresp.
  - Otherwise, if pendX: mX_hready=0, mX_hresp=0.
  - Otherwise: mX_hready=1, mX_hresp=0.
- Read data: mX_hrdata=s_hrdata, broadcast to both masters.
- Write data: s_hwdata = (owner==M1) ? m1_hwdata : m0_hwdata. A buffered master holds hwdata through its stretched data phase.
- Latency:
  - Uncontended transfer: zero added cycles.
  - Contended transfer: stalled one slave transfer per competing grant.
- ERROR: the two-cycle response passes through to the owner unchanged. A master issuing IDLE on the second ERROR cycle cancels nothing in the buffer, because capture happens only when its hready is 1.
- Reset mid-operation: buffered transfers are discarded, never issued, and owner is cleared. An in-flight slave transfer is abandoned; the slave is reset by the same sys_resetn.

Decomposition:
- Shared package iahb_arb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, owner encoding OWN_NONE/OWN_M0/OWN_M1.
- Sub-module iahb_arb_req_buf (one-entry address-phase buffer with valid bit; load and clear inputs), instantiated twice.

Test Plan:
- M0 read 0x0000_0100, M1 idle, zero-wait slave -> s_htrans=NONSEQ and s_haddr=0x100 in the same cycle; m0_hready=1 throughout; m0_hrdata=s_hrdata next cycle.
- First cycle after reset, M0 read 0x0 and M1 write 0x2000_0010 with data 0xDEADBEEF -> M0 is granted; M1 is buffered with m1_hready=0 for one cycle; next cycle s_haddr=0x2000_0010 with s_hwrite=1; the following cycle s_hwdata=0xDEADBEEF.
- Both masters issuing continuously -> grants alternate M0,M1,M0,M1; each master sees hready=0 on alternate data phases; no transfer is lost or duplicated (scoreboard count equal).
- s_hready held 0 for 2 cycles while M1 presents a NONSEQ read 0x40 -> s_htrans=IDLE during the wait; pend1=1; 0x40 is issued in the first cycle with s_hready=1.
- Slave ERROR on an M0 transfer -> m0 sees hresp=1/hready=0, then hresp=1/hready=1; m1_hresp stays 0; a subsequent M1 transfer completes OKAY.
- sys_resetn low for one cycle while pend1=1 -> next cycle pend1=0, owner=NONE, m0_hready=m1_hready=1, s_htrans=IDLE; the buffered M1 address never appears on s_haddr.
